lcd_pattern_gen: RTL and testbench
==================================

LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch in clocks
- H_SYNC, 41, Hsync low width in clocks
- H_BP, 2, horizontal back porch in clocks
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch in lines
- V_SYNC, 10, Vsync low width in lines
- V_BP, 2, vertical back porch in lines
- CW, 8, bits per colour channel
- SPLIT_COL, 240, split column for mode 1
- PWR_FRAMES, 2, frames of power-on delay and power-off blanking
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk_lcd, in, 1, pixel clock; the single clock
- rst, in, 1, synchronous active-high reset
- disp_en, in, 1, panel enable request
- mode, in, 3, pattern select
- color_a, in, 3*CW, colour {R,G,B}
- color_b, in, 3*CW, colour {R,G,B}
- Hsync, out, 1, active-low horizontal sync
- Vsync, out, 1, active-low vertical sync
- DE, out, 1, data enable
- DISP, out, 1, panel power enable
- data_RED, out, CW, red pixel
- data_GREEN, out, CW, green pixel
- data_BLUE, out, CW, blue pixel
- frame_start, out, 1, one-clock pulse at pixel (0,0)
- hcount, out, 10, current column
- vcount, out, 10, current line

Function
REQ-003 hcount SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters = 525) and wrap to 0; vcount SHALL increment on each hcount wrap and wrap to 0 after V_TOTAL-1 (V_TOTAL = 286).
REQ-004 Each line and each frame SHALL be ordered active, front porch, sync, back porch; Hsync SHALL be 0 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); Vsync SHALL follow the same rule on vcount.
REQ-005 Hsync, Vsync, DE, RGB and frame_start SHALL all be registered with exactly one clock of latency from the counter values, mutually aligned.
REQ-006 frame_start SHALL pulse for one clock when the counters are (0,0).
REQ-007 mode, color_a and color_b SHALL be sampled only when the counters are (0,0); changes at any other time SHALL take effect at the next frame.
REQ-008 Pattern by latched mode, with x = hcount and y = vcount:
- 0: color_a
- 1: color_a if x < SPLIT_COL, else color_b
- 2: eight bars, bar index k = x/(H_ACTIVE/8) saturated at 7; R, G, B are all-ones when k[2], k[1], k[0] respectively are set, else zero
- 3: checkerboard; color_a if x[4]^y[4] = 0, else color_b
- 4: grey ramp; R = G = B = x[CW-1:0], wrapping
- 5-7: black
REQ-009 RGB SHALL be 0 whenever DE = 0 or the power state is not ON.
REQ-010 The power FSM SHALL have states OFF, WAIT_ON, ON and BLANK, with these transitions:
- OFF to WAIT_ON when disp_en = 1
- WAIT_ON to ON after PWR_FRAMES frame_start pulses
- ON to BLANK when disp_en = 0
- BLANK to OFF after PWR_FRAMES frame_start pulses
REQ-011 DISP SHALL be 1 in ON and BLANK and 0 in OFF and WAIT_ON.
REQ-012 disp_en = 0 in WAIT_ON SHALL return the FSM to OFF on the next clock; disp_en = 1 in BLANK SHALL return it to ON at the next frame_start.
REQ-013 The frame counter SHALL be cleared on every state transition.
REQ-014 Timing generation SHALL run continuously, independent of the power state.

Reset
REQ-015 When rst = 1 at a clk_lcd edge, the block SHALL set:
- hcount and vcount to 0
- Hsync and Vsync to 1
- DE, DISP and frame_start to 0
- RGB to 0
- FSM to OFF, frame counter to 0
- latched mode to 0, latched colours to 0
REQ-016 Reset asserted mid-frame or mid-sequence SHALL take effect on that edge, with no partial frame completed.

Structure
REQ-017 Package lcd_pkg SHALL hold the power-state enum, the mode encodings (MODE_SOLID, MODE_SPLIT, MODE_BARS, MODE_CHECKER, MODE_RAMP) and the default timing constants.
REQ-018 Sub-module lcd_timing SHALL contain the counters and the sync, DE and frame_start generation; lcd_pattern_gen SHALL contain the pattern mux and the power FSM.

Verification
REQ-019 Timing: after reset, run 2 frames -> Hsync low 41 clocks starting at hcount 482; Vsync low 10 lines starting at vcount 274; 525 x 286 clocks per frame.
REQ-020 Split: mode 1, color_a = FFFF00, color_b = 00FFFF -> pixel 239 is FFFF00, pixel 240 is 00FFFF, one clock after the counter value.
REQ-021 Mid-frame change: switch mode 0 to 2 at line 100 -> rest of frame stays solid; bars start at the next frame_start; bar 7 = FFFFFF at x = 420.
REQ-022 Power: raise disp_en -> DISP rises after 2 frame_starts; drop disp_en -> RGB is 0 at once and DISP falls after 2 more frame_starts.
REQ-023 Abort cases: drop disp_en during WAIT_ON -> FSM is OFF next clock and DISP stays 0; raise disp_en during BLANK -> ON at the next frame_start.
REQ-024 Reset mid-frame at (300,150) -> all outputs equal their reset values on the next clock, then a frame_start occurs one clock after rst is released.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and defaults for the LCD pattern generator.
//   pwr_state_e  - panel power sequencing states
//   MODE_*       - pattern select encodings (5..7 render black)
//   DEF_*        - default 480x272 panel timing and block defaults
package lcd_pkg;

    typedef enum logic [1:0] {
        PWR_OFF     = 2'd0,
        PWR_WAIT_ON = 2'd1,
        PWR_ON      = 2'd2,
        PWR_BLANK   = 2'd3
    } pwr_state_e;

    localparam logic [2:0] MODE_SOLID   = 3'd0;
    localparam logic [2:0] MODE_SPLIT   = 3'd1;
    localparam logic [2:0] MODE_BARS    = 3'd2;
    localparam logic [2:0] MODE_CHECKER = 3'd3;
    localparam logic [2:0] MODE_RAMP    = 3'd4;

    localparam int DEF_H_ACTIVE   = 480;
    localparam int DEF_H_FP       = 2;
    localparam int DEF_H_SYNC     = 41;
    localparam int DEF_H_BP       = 2;
    localparam int DEF_V_ACTIVE   = 272;
    localparam int DEF_V_FP       = 2;
    localparam int DEF_V_SYNC     = 10;
    localparam int DEF_V_BP       = 2;
    localparam int DEF_CW         = 8;
    localparam int DEF_SPLIT_COL  = 240;
    localparam int DEF_PWR_FRAMES = 2;

    // Width of the hcount/vcount counters.
    localparam int CNT_W = 10;

endpackage

// File: rtl/lcd_timing.sv
// lcd_timing: free-running raster counters plus registered sync/DE/frame_start.
//   clk_i, rst_i       - pixel clock, synchronous active-high reset
//   hcount_o, vcount_o - current counter values
//   active_o, origin_o - combinational: counters inside visible area / at (0,0)
//   hsync_o, vsync_o   - active-low syncs, one clock behind the counters
//   de_o               - data enable, one clock behind the counters
//   frame_start_o      - one-clock pulse, one clock after counters were (0,0)
module lcd_timing
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] hcount_o,
    output logic [CNT_W-1:0] vcount_o,
    output logic             active_o,
    output logic             origin_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic             frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             hs_q, vs_q, de_q, fs_q;
    logic             hs_d, vs_d;

    always_comb begin
        h_d = h_q + ONE;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
        end
    end

    assign active_o = (h_q < H_ACT) && (v_q < V_ACT);
    assign origin_o = (h_q == '0) && (v_q == '0);
    assign hs_d     = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign vs_d     = !((v_q >= VS_BEG) && (v_q < VS_END));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            de_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= active_o;
            fs_q <= origin_o;
        end
    end

    assign hcount_o      = h_q;
    assign vcount_o      = v_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign de_o          = de_q;
    assign frame_start_o = fs_q;

endmodule

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: RGB LCD test-pattern source with panel power sequencing.
//   clk_lcd, rst          - pixel clock, synchronous active-high reset
//   disp_en               - panel enable request
//   mode, color_a/b       - pattern select and colours {R,G,B}, latched per frame
//   Hsync, Vsync, DE      - panel timing (registered, aligned with RGB)
//   DISP                  - panel power enable
//   data_RED/GREEN/BLUE   - pixel data, black outside DE or when not powered ON
//   frame_start           - one-clock pulse aligned with pixel (0,0)
//   hcount, vcount        - raster counters
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int CW         = DEF_CW,
    parameter int SPLIT_COL  = DEF_SPLIT_COL,
    parameter int PWR_FRAMES = DEF_PWR_FRAMES
) (
    input  logic            clk_lcd,
    input  logic            rst,
    input  logic            disp_en,
    input  logic [2:0]      mode,
    input  logic [3*CW-1:0] color_a,
    input  logic [3*CW-1:0] color_b,
    output logic            Hsync,
    output logic            Vsync,
    output logic            DE,
    output logic            DISP,
    output logic [CW-1:0]   data_RED,
    output logic [CW-1:0]   data_GREEN,
    output logic [CW-1:0]   data_BLUE,
    output logic            frame_start,
    output logic [9:0]      hcount,
    output logic [9:0]      vcount
);

    localparam int PIX_W = 3 * CW;
    localparam int FCW   = (PWR_FRAMES < 2) ? 1 : $clog2(PWR_FRAMES);

    localparam logic [FCW-1:0]   FC_ONE    = FCW'(1);
    localparam logic [FCW-1:0]   FC_LAST   = FCW'(PWR_FRAMES - 1);
    localparam logic [CNT_W-1:0] BAR_W_C   = CNT_W'(H_ACTIVE / 8);
    localparam logic [CNT_W-1:0] SPLIT_C   = CNT_W'(SPLIT_COL);

    logic [CNT_W-1:0] h_w, v_w;
    logic             active_w, origin_w, fs_w;

    lcd_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk_i         (clk_lcd),
        .rst_i         (rst),
        .hcount_o      (h_w),
        .vcount_o      (v_w),
        .active_o      (active_w),
        .origin_o      (origin_w),
        .hsync_o       (Hsync),
        .vsync_o       (Vsync),
        .de_o          (DE),
        .frame_start_o (fs_w)
    );

    assign frame_start = fs_w;
    assign hcount      = h_w;
    assign vcount      = v_w;

    // ---------------- per-frame latch of mode/colours ----------------
    logic [2:0]       mode_q;
    logic [PIX_W-1:0] ca_q, cb_q;
    logic [2:0]       eff_mode;
    logic [PIX_W-1:0] eff_a, eff_b;

    // Pixel (0,0) is rendered on the same edge the inputs are latched, so it
    // uses the incoming values directly; the new frame is uniform from its
    // first pixel.
    always_comb begin
        eff_mode = origin_w ? mode    : mode_q;
        eff_a    = origin_w ? color_a : ca_q;
        eff_b    = origin_w ? color_b : cb_q;
    end

    always_ff @(posedge clk_lcd) begin
        if (rst) begin
            mode_q <= '0;
            ca_q   <= '0;
            cb_q   <= '0;
        end else if (origin_w) begin
            mode_q <= mode;
            ca_q   <= color_a;
            cb_q   <= color_b;
        end
    end

    // ---------------- pattern mux ----------------
    logic [CNT_W-1:0] bar_idx;
    logic [2:0]       bar_k;
    logic [PIX_W-1:0] pix;

    always_comb begin
        bar_idx = h_w / BAR_W_C;
        // Leftover columns when H_ACTIVE is not a multiple of 8 stay in bar 7.
        bar_k   = (|bar_idx[CNT_W-1:3]) ? 3'd7 : bar_idx[2:0];
        pix     = '0;
        case (eff_mode)
            MODE_SOLID:   pix = eff_a;
            MODE_SPLIT:   pix = (h_w < SPLIT_C) ? eff_a : eff_b;
            MODE_BARS:    pix = {{CW{bar_k[2]}}, {CW{bar_k[1]}}, {CW{bar_k[0]}}};
            MODE_CHECKER: pix = (h_w[4] ^ v_w[4]) ? eff_b : eff_a;
            MODE_RAMP:    pix = {3{h_w[CW-1:0]}};
            default:      pix = '0;
        endcase
    end

    // ---------------- power FSM ----------------
    pwr_state_e     state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            PWR_OFF: begin
                if (disp_en) state_d = PWR_WAIT_ON;
            end
            PWR_WAIT_ON: begin
                if (!disp_en) begin
                    state_d = PWR_OFF;
                end else if (fs_w) begin
                    if (fcnt_q == FC_LAST) state_d = PWR_ON;
                    else                   fcnt_d  = fcnt_q + FC_ONE;
                end
            end
            PWR_ON: begin
                if (!disp_en) state_d = PWR_BLANK;
            end
            PWR_BLANK: begin
                if (fs_w) begin
                    if (disp_en)                state_d = PWR_ON;
                    else if (fcnt_q == FC_LAST) state_d = PWR_OFF;
                    else                        fcnt_d  = fcnt_q + FC_ONE;
                end
            end
            default: state_d = PWR_OFF;
        endcase
        if (state_d != state_q) fcnt_d = '0;
    end

    always_ff @(posedge clk_lcd) begin
        if (rst) begin
            state_q <= PWR_OFF;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign DISP = (state_q == PWR_ON) || (state_q == PWR_BLANK);

    // ---------------- RGB output register ----------------
    // Gating on the next state blanks RGB on the very edge the FSM leaves ON.
    logic [PIX_W-1:0] rgb_q, rgb_d;

    assign rgb_d = (active_w && (state_d == PWR_ON)) ? pix : '0;

    always_ff @(posedge clk_lcd) begin
        if (rst) rgb_q <= '0;
        else     rgb_q <= rgb_d;
    end

    assign data_RED   = rgb_q[3*CW-1:2*CW];
    assign data_GREEN = rgb_q[2*CW-1:CW];
    assign data_BLUE  = rgb_q[CW-1:0];

endmodule

// File: tb/tb_lcd_pattern_gen.sv
module tb_lcd_pattern_gen;

    localparam int HA = 50, HF = 2, HS = 4, HB = 2;
    localparam int VA = 24, VF = 1, VS = 2, VB = 1;
    localparam int CW = 8, SC = 20, PF = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int BW = HA / 8;
    localparam int P_OFF = 0, P_WAIT = 1, P_ON = 2, P_BLANK = 3;

    logic        clk_lcd = 1'b0;
    logic        rst = 1'b1;
    logic        disp_en = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [23:0] color_a = '0, color_b = '0;
    logic        Hsync, Vsync, DE, DISP, frame_start;
    logic [7:0]  data_RED, data_GREEN, data_BLUE;
    logic [9:0]  hcount, vcount;

    lcd_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CW (CW), .SPLIT_COL (SC), .PWR_FRAMES (PF)
    ) dut (
        .clk_lcd (clk_lcd), .rst (rst), .disp_en (disp_en), .mode (mode),
        .color_a (color_a), .color_b (color_b),
        .Hsync (Hsync), .Vsync (Vsync), .DE (DE), .DISP (DISP),
        .data_RED (data_RED), .data_GREEN (data_GREEN), .data_BLUE (data_BLUE),
        .frame_start (frame_start), .hcount (hcount), .vcount (vcount)
    );

    always #5 clk_lcd = ~clk_lcd;

    int tests = 0, fails = 0;

    // ---------------- reference model ----------------
    // Time since reset release gives the raster position by plain division.
    int          t = 0, ph = -1, pv = -1, ch = 0, cv = 0;
    logic        e_hs = 1, e_vs = 1, e_de = 0, e_fs = 0;
    logic [23:0] e_rgb = '0;
    int          pst = P_OFF, pcnt = 0;
    logic [2:0]  lm = 0;
    logic [23:0] la = 0, lb = 0;

    function automatic logic [23:0] ref_pix(logic [2:0] md, int x, int y,
                                            logic [23:0] a, logic [23:0] b);
        int k;
        logic [7:0] g;
        case (md)
            3'd0: return a;
            3'd1: return (x < SC) ? a : b;
            3'd2: begin
                k = x / BW;
                if (k > 7) k = 7;
                return {((k & 4) != 0) ? 8'hFF : 8'h00,
                        ((k & 2) != 0) ? 8'hFF : 8'h00,
                        ((k & 1) != 0) ? 8'hFF : 8'h00};
            end
            3'd3: return ((((x >> 4) ^ (y >> 4)) & 1) == 0) ? a : b;
            3'd4: begin g = 8'(x % 256); return {g, g, g}; end
            default: return 24'h0;
        endcase
    endfunction

    always @(posedge clk_lcd) begin
        if (rst) begin
            t = 0; ph = -1; pv = -1;
            e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_rgb = 0;
            pst = P_OFF; pcnt = 0; lm = 0; la = 0; lb = 0;
        end else begin
            ph = t % HT;
            pv = (t / HT) % VT;
            if (ph == 0 && pv == 0) begin lm = mode; la = color_a; lb = color_b; end
            // power rules; e_fs still holds the pulse visible before this edge
            case (pst)
                P_OFF:  if (disp_en) begin pst = P_WAIT; pcnt = 0; end
                P_WAIT: if (!disp_en) begin pst = P_OFF; pcnt = 0; end
                        else if (e_fs) begin
                            pcnt++;
                            if (pcnt >= PF) begin pst = P_ON; pcnt = 0; end
                        end
                P_ON:   if (!disp_en) begin pst = P_BLANK; pcnt = 0; end
                default: if (e_fs) begin
                            pcnt++;
                            if (disp_en) begin pst = P_ON; pcnt = 0; end
                            else if (pcnt >= PF) begin pst = P_OFF; pcnt = 0; end
                        end
            endcase
            e_hs  = !(ph >= HA + HF && ph < HA + HF + HS);
            e_vs  = !(pv >= VA + VF && pv < VA + VF + VS);
            e_de  = (ph < HA) && (pv < VA);
            e_fs  = (ph == 0) && (pv == 0);
            e_rgb = (e_de && pst == P_ON) ? ref_pix(lm, ph, pv, la, lb) : 24'h0;
            t = t + 1;
        end
        ch = t % HT;
        cv = (t / HT) % VT;
    end

    function automatic logic [48:0] exp_vec();
        return {e_hs, e_vs, e_de, (pst == P_ON || pst == P_BLANK), e_fs, e_rgb,
                10'(ch), 10'(cv)};
    endfunction

    function automatic logic [48:0] dut_vec();
        return {Hsync, Vsync, DE, DISP, frame_start, data_RED, data_GREEN, data_BLUE,
                hcount, vcount};
    endfunction

    logic [48:0] got;

    task automatic tick();
        @(negedge clk_lcd);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if ({Hsync, Vsync, DE, DISP, frame_start} !== 5'b11000) begin
            fails++; $display("FAIL reset_ctl got=%b want=11000",
                              {Hsync, Vsync, DE, DISP, frame_start});
        end
        tests++;
        if ({data_RED, data_GREEN, data_BLUE, hcount, vcount} !== 44'h0) begin
            fails++; $display("FAIL reset_data got rgb=%h h=%0d v=%0d want 0",
                              {data_RED, data_GREEN, data_BLUE}, hcount, vcount);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (frame_start !== 1'b1 || hcount !== 10'd1 || vcount !== 10'd0) begin
            fails++; $display("FAIL reset_release fs=%b h=%0d v=%0d want fs=1 h=1 v=0",
                              frame_start, hcount, vcount);
        end
        got = dut_vec(); tests++;
        if (got !== exp_vec()) begin
            fails++; $display("FAIL reset_model got=%h want=%h", got, exp_vec());
        end
    endtask

    task automatic test_timing();
        int run_h = 0, run_v = 0, last_fs = -1;
        logic prev_h = 1'b1, prev_v = 1'b1;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL timing_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (!Hsync) begin
                if (prev_h) begin
                    tests++;
                    if (int'(hcount) != HA + HF + 1) begin
                        fails++; $display("FAIL hsync_start hcount=%0d want=%0d", hcount, HA + HF + 1);
                    end
                end
                run_h++;
            end else if (!prev_h) begin
                tests++;
                if (run_h != HS) begin
                    fails++; $display("FAIL hsync_width got=%0d want=%0d", run_h, HS);
                end
                run_h = 0;
            end
            if (!Vsync) begin
                if (prev_v) begin
                    tests++;
                    if (int'(vcount) != VA + VF) begin
                        fails++; $display("FAIL vsync_start vcount=%0d want=%0d", vcount, VA + VF);
                    end
                end
                run_v++;
            end else if (!prev_v) begin
                tests++;
                if (run_v != VS * HT) begin
                    fails++; $display("FAIL vsync_width got=%0d want=%0d", run_v, VS * HT);
                end
                run_v = 0;
            end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    tests++;
                    if (i - last_fs != FR) begin
                        fails++; $display("FAIL frame_period got=%0d want=%0d", i - last_fs, FR);
                    end
                end
                last_fs = i;
            end
            prev_h = Hsync;
            prev_v = Vsync;
        end
    endtask

    task automatic test_power_on();
        int nfs = 0;
        logic done = 1'b0;
        mode    = 3'($urandom_range(0, 4));
        color_a = 24'($urandom);
        color_b = 24'($urandom);
        disp_en = 1'b1;
        for (int i = 0; i < 4 * FR && !done; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL power_on_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (DISP) done = 1'b1;
            else if (frame_start) nfs++;
        end
        tests++;
        if (!done || nfs != PF) begin
            fails++; $display("FAIL power_on_delay risen=%b frame_starts=%0d want %0d", done, nfs, PF);
        end
    endtask

    task automatic test_split();
        logic seen = 1'b0;
        mode = 3'd1; color_a = 24'hFFFF00; color_b = 24'h00FFFF;
        for (int i = 0; i < 2 * FR + 2; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL split_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (e_fs) seen = 1'b1;
            if (seen && pv < VA && (ph == SC - 1 || ph == SC)) begin
                tests++;
                if ({data_RED, data_GREEN, data_BLUE} !== ((ph == SC) ? 24'h00FFFF : 24'hFFFF00)) begin
                    fails++; $display("FAIL split_edge x=%0d got=%h want=%h", ph,
                                      {data_RED, data_GREEN, data_BLUE},
                                      (ph == SC) ? 24'h00FFFF : 24'hFFFF00);
                end
            end
        end
    endtask

    task automatic test_midframe_change();
        logic [23:0] a = 24'($urandom) | 24'h010101;
        logic seen = 1'b0, switched = 1'b0, next = 1'b0;
        int stop = 0;
        mode = 3'd0; color_a = a;
        for (int i = 0; i < 4 * FR && stop < FR; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL midframe_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (e_fs && switched) next = 1'b1;
            if (e_fs) seen = 1'b1;
            if (switched && !next && ph < HA && pv < VA) begin
                tests++;
                if ({data_RED, data_GREEN, data_BLUE} !== a) begin
                    fails++; $display("FAIL midframe_hold x=%0d y=%0d got=%h want=%h", ph, pv,
                                      {data_RED, data_GREEN, data_BLUE}, a);
                end
            end
            if (next && pv == 3 && (ph == 7 * BW || ph == HA - 1 || ph == BW)) begin
                tests++;
                if ({data_RED, data_GREEN, data_BLUE} !== ((ph == BW) ? 24'h0000FF : 24'hFFFFFF)) begin
                    fails++; $display("FAIL bars x=%0d got=%h want=%h", ph,
                                      {data_RED, data_GREEN, data_BLUE},
                                      (ph == BW) ? 24'h0000FF : 24'hFFFFFF);
                end
            end
            if (seen && !switched && cv == 10 && ch == 0) begin
                mode = 3'd2; switched = 1'b1;
            end
            if (next) stop++;
        end
        tests++;
        if (!next) begin
            fails++; $display("FAIL midframe_timeout next_frame=%b want 1", next);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4 * FR; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL random_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if ($urandom_range(0, 299) == 0) begin
                mode    = 3'($urandom_range(0, 7));
                color_a = 24'($urandom);
                color_b = 24'($urandom);
            end
        end
    endtask

    task automatic test_power_off();
        int nfs = 0;
        logic done = 1'b0, first = 1'b1, armed = 1'b0;
        mode = 3'd0; color_a = 24'h123456;
        for (int i = 0; i < 6 * FR && !done; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL power_off_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (!disp_en) begin
                if (first) begin
                    tests++;
                    if ({data_RED, data_GREEN, data_BLUE} !== 24'h0 || DISP !== 1'b1) begin
                        fails++; $display("FAIL power_off_blank rgb=%h disp=%b want rgb=0 disp=1",
                                          {data_RED, data_GREEN, data_BLUE}, DISP);
                    end
                    first = 1'b0;
                end
                if (!DISP) done = 1'b1;
                else if (frame_start) nfs++;
            end else begin
                if (e_fs) armed = 1'b1;
                if (armed && cv == 5 && ch == 10) disp_en = 1'b0;
            end
        end
        tests++;
        if (!done || nfs != PF) begin
            fails++; $display("FAIL power_off_delay fell=%b frame_starts=%0d want %0d", done, nfs, PF);
        end
    endtask

    task automatic test_abort();
        int bad = 0, nfs = 0, stage = 0;
        logic done = 1'b0;
        // WAIT_ON abort: drop enable after the first frame_start
        disp_en = 1'b1;
        for (int i = 0; i < 2 * FR && stage == 0; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL abort_wait_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (frame_start) stage = 1;
        end
        disp_en = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL abort_off_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (DISP) bad++;
        end
        tests++;
        if (stage != 1 || bad != 0) begin
            fails++; $display("FAIL abort_wait stage=%0d disp_high_cycles=%0d want stage 1, 0 cycles", stage, bad);
        end
        // restart must again take the full delay
        disp_en = 1'b1;
        for (int i = 0; i < 4 * FR && !done; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL abort_restart_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (DISP) done = 1'b1;
            else if (frame_start) nfs++;
        end
        tests++;
        if (!done || nfs != PF) begin
            fails++; $display("FAIL abort_restart risen=%b frame_starts=%0d want %0d", done, nfs, PF);
        end
        // BLANK abort: drop mid-frame, re-enable after one frame_start
        stage = 0; bad = 0;
        for (int i = 0; i < 5 * FR && stage < 4; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL abort_blank_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (!DISP) bad++;
            case (stage)
                0: if (cv == 5 && ch == 10) begin disp_en = 1'b0; stage = 1; end
                1: if (frame_start) begin disp_en = 1'b1; stage = 2; end
                2: if (frame_start) stage = 3;
                default: if (pv == 5 && ph == 10) begin
                    tests++;
                    if ({data_RED, data_GREEN, data_BLUE} !== color_a) begin
                        fails++; $display("FAIL abort_blank_resume got=%h want=%h",
                                          {data_RED, data_GREEN, data_BLUE}, color_a);
                    end
                    stage = 4;
                end
            endcase
        end
        tests++;
        if (stage != 4 || bad != 0) begin
            fails++; $display("FAIL abort_blank stage=%0d disp_low_cycles=%0d want stage 4, 0 cycles", stage, bad);
        end
    endtask

    task automatic test_reset_midframe();
        logic hit = 1'b0;
        for (int i = 0; i < 2 * FR && !hit; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL pre_reset_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
            if (ch == 30 && cv == 15) hit = 1'b1;
        end
        rst = 1'b1;
        tick();
        tests++;
        if (!hit || dut_vec() !== {5'b11000, 24'h0, 20'h0}) begin
            fails++; $display("FAIL reset_midframe hit=%b got=%h want=%h", hit, dut_vec(),
                              {5'b11000, 24'h0, 20'h0});
        end
        rst = 1'b0;
        tick();
        tests++;
        if (frame_start !== 1'b1 || hcount !== 10'd1 || vcount !== 10'd0 || DISP !== 1'b0) begin
            fails++; $display("FAIL reset_midframe_release fs=%b h=%0d v=%0d disp=%b want 1,1,0,0",
                              frame_start, hcount, vcount, DISP);
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            got = dut_vec(); tests++;
            if (got !== exp_vec()) begin
                fails++; $display("FAIL post_reset_model t=%0d got=%h want=%h", t, got, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_power_on();
        test_split();
        test_midframe_change();
        test_random();
        test_power_off();
        test_abort();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
